bus_driver_reg: RTL and testbench



---
 rtl/bus_driver_reg_pkg.sv | 28 ++
 rtl/bus_driver_reg_turn_timer.sv | 39 +++
 rtl/bus_driver_reg.sv | 121 ++++++++++++
 tb/tb_bus_driver_reg.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_driver_reg_pkg.sv
// Shared definitions for the registered tri-state bus driver: FSM state
// encodings, turnaround counter width and the counter preload helper.
package bus_driver_reg_pkg;

   // Bus ownership states; the encodings are fixed so that waveform
   // viewers and any software reading them agree.
   typedef enum logic [1:0] {
      HIZ     = 2'd0,
      TURNING = 2'd1,
      DRIVE   = 2'd2
   } drvState_e;

   localparam int CNT_W    = 4;
   localparam int TURN_MAX = 15;

   // Value preloaded into the turnaround counter when leaving HIZ. The
   // counter has to reach zero once more before DRIVE is entered, so it
   // starts one below the requested delay. TURN==0 never loads it.
   function automatic logic [CNT_W-1:0] turnLoad(input int turn);
      logic [CNT_W-1:0] val;
      val = '0;
      if (turn > 0) begin
         val = CNT_W'(turn - 1);
      end
      return val;
   endfunction

endpackage

// File: rtl/bus_driver_reg_turn_timer.sv
// Loadable 4-bit down-counter with a zero flag. It measures the bus
// turnaround so the driver never overlaps the previous bus owner.
module turn_timer
   import bus_driver_reg_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: a load wins over a decrement, and the count never
   // wraps below zero even if a decrement is requested at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter register, cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bus_driver_reg.sv
// Registered tri-state bus driver with two active-low enables and a
// programmable turnaround delay before it takes the shared bus.
module bus_driver_reg
   import bus_driver_reg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int TURN  = 2,
   parameter int LATCH = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             noe1,
   input  logic             noe2,
   input  logic             le,
   input  logic [WIDTH-1:0] a,
   output tri   [WIDTH-1:0] y,
   output logic             drive,
   output logic             busy
);

   // Reject parameter values the 4-bit turnaround counter or the bus
   // width range cannot honour.
   if ((TURN < 0) || (TURN > TURN_MAX)) begin : g_turnRange
      $error("bus_driver_reg: TURN must be in 0..15");
   end
   if ((WIDTH < 1) || (WIDTH > 32)) begin : g_widthRange
      $error("bus_driver_reg: WIDTH must be in 1..32");
   end

   drvState_e        state_q;
   drvState_e        state_d;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;
   logic             en;
   logic             cntLoad;
   logic             cntDec;
   logic             cntZero;

   // Only a clean 0 on both enables counts; X or Z keeps the bus released.
   assign en = (noe1 === 1'b0) && (noe2 === 1'b0);

   // Data capture: transparent register every clock, or only on le.
   always_comb begin
      data_d = data_q;
      if ((LATCH == 0) || (le == 1'b1)) begin
         data_d = a;
      end
   end

   // Data register, cleared by reset so a fresh bus owner never shows
   // stale data.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   // Ownership FSM: any enable dropout returns to HIZ, so the full
   // turnaround is always required after re-enabling.
   always_comb begin
      state_d = state_q;
      cntLoad = 1'b0;
      cntDec  = 1'b0;
      case (state_q)
         HIZ: begin
            if (en) begin
               if (TURN == 0) begin
                  state_d = DRIVE;
               end else begin
                  state_d = TURNING;
                  cntLoad = 1'b1;
               end
            end
         end
         TURNING: begin
            if (!en) begin
               state_d = HIZ;
            end else if (cntZero) begin
               state_d = DRIVE;
            end else begin
               cntDec = 1'b1;
            end
         end
         DRIVE: begin
            if (!en) begin
               state_d = HIZ;
            end
         end
         default: begin
            state_d = HIZ;
         end
      endcase
   end

   // State register; reset releases the bus at the reset edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= HIZ;
      end else begin
         state_q <= state_d;
      end
   end

   turn_timer u_turnTimer (
      .clk        (clk),
      .reset      (reset),
      .load_i     (cntLoad),
      .load_val_i (turnLoad(TURN)),
      .dec_i      (cntDec),
      .zero_o     (cntZero)
   );

   // The release path stays combinational from the enables so the bus
   // is let go in the same cycle they are deasserted.
   assign drive = (state_q == DRIVE) && en;
   assign busy  = (state_q == TURNING);
   assign y     = drive ? data_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_driver_reg.sv
// Self-checking bench for bus_driver_reg: four configurations share one
// stimulus stream and are compared every cycle against a run-length model.
module tb_bus_driver_reg;

   logic        clk = 1'b0;
   logic        reset;
   logic        noe1;
   logic        noe2;
   logic        le;
   logic [31:0] aIn;

   wire  [7:0]  y0;
   wire  [7:0]  y1;
   wire  [15:0] y2;
   wire  [7:0]  y3;
   logic [3:0]  driveV;
   logic [3:0]  busyV;

   int nChecks = 0;
   int nFails  = 0;

   // Model state: consecutive enabled edges seen and the captured word.
   int          run [4];
   logic [31:0] mData [4];
   bit          modelValid = 1'b0;

   always #5 clk = ~clk;

   bus_driver_reg #(.WIDTH(8), .TURN(2), .LATCH(0)) u0 (
      .clk(clk), .reset(reset), .noe1(noe1), .noe2(noe2), .le(le),
      .a(aIn[7:0]), .y(y0), .drive(driveV[0]), .busy(busyV[0]));
   bus_driver_reg #(.WIDTH(8), .TURN(2), .LATCH(1)) u1 (
      .clk(clk), .reset(reset), .noe1(noe1), .noe2(noe2), .le(le),
      .a(aIn[7:0]), .y(y1), .drive(driveV[1]), .busy(busyV[1]));
   bus_driver_reg #(.WIDTH(16), .TURN(0), .LATCH(0)) u2 (
      .clk(clk), .reset(reset), .noe1(noe1), .noe2(noe2), .le(le),
      .a(aIn[15:0]), .y(y2), .drive(driveV[2]), .busy(busyV[2]));
   bus_driver_reg #(.WIDTH(8), .TURN(15), .LATCH(0)) u3 (
      .clk(clk), .reset(reset), .noe1(noe1), .noe2(noe2), .le(le),
      .a(aIn[7:0]), .y(y3), .drive(driveV[3]), .busy(busyV[3]));

   function automatic int turnOf(input int i);
      case (i)
         0: return 2;
         1: return 2;
         2: return 0;
         default: return 15;
      endcase
   endfunction

   function automatic int widthOf(input int i);
      return (i == 2) ? 16 : 8;
   endfunction

   function automatic bit latchOf(input int i);
      return (i == 1);
   endfunction

   function automatic logic [31:0] yOf(input int i);
      case (i)
         0: return {24'h0, y0};
         1: return {24'h0, y1};
         2: return {16'h0, y2};
         default: return {24'h0, y3};
      endcase
   endfunction

   // A released bus reads Z; a simulator without 4-state nets reads it as 0.
   function automatic bit busMatches(input logic [31:0] yv, input int w,
                                     input bit expDrv, input logic [31:0] expD);
      bit ok;
      ok = 1'b1;
      for (int b = 0; b < w; b++) begin
         if (expDrv) begin
            if (yv[b] !== expD[b]) ok = 1'b0;
         end else begin
            if ((yv[b] !== 1'bz) && (yv[b] !== 1'b0)) ok = 1'b0;
         end
      end
      return ok;
   endfunction

   // Model update on every rising edge: an enabled edge extends the run,
   // anything else (or reset) ends it.
   always @(posedge clk) begin
      bit enS;
      enS = (noe1 === 1'b0) && (noe2 === 1'b0);
      for (int i = 0; i < 4; i++) begin
         if (reset) begin
            run[i]   = 0;
            mData[i] = '0;
         end else begin
            run[i] = enS ? ((run[i] < 31) ? run[i] + 1 : run[i]) : 0;
            if (!latchOf(i) || le) begin
               mData[i] = aIn & ((widthOf(i) == 32) ? 32'hFFFF_FFFF
                                                    : ((32'h1 << widthOf(i)) - 32'h1));
            end
         end
      end
      modelValid = 1'b1;
   end

   // Compare every instance against the model away from the active edge.
   always @(negedge clk) begin
      if (modelValid) begin
         for (int i = 0; i < 4; i++) begin
            bit en;
            bit expDrv;
            bit expBusy;
            en      = (noe1 === 1'b0) && (noe2 === 1'b0);
            expDrv  = en && (run[i] > turnOf(i));
            expBusy = (run[i] >= 1) && (run[i] <= turnOf(i));
            nChecks++;
            if (driveV[i] !== expDrv) begin
               nFails++;
               $display("[TB] FAIL model drive u%0d at %0t: got %b expected %b",
                        i, $time, driveV[i], expDrv);
            end
            nChecks++;
            if (busyV[i] !== expBusy) begin
               nFails++;
               $display("[TB] FAIL model busy u%0d at %0t: got %b expected %b",
                        i, $time, busyV[i], expBusy);
            end
            nChecks++;
            if (!busMatches(yOf(i), widthOf(i), expDrv, mData[i])) begin
               nFails++;
               $display("[TB] FAIL model y u%0d at %0t: got %h expected %s%h",
                        i, $time, yOf(i), expDrv ? "" : "Z, not ", mData[i]);
            end
         end
      end
   end

   task automatic applyStimulus(input bit rst, input bit n1, input bit n2,
                                input bit leV, input logic [31:0] aV);
      @(posedge clk);
      #1;
      reset = rst;
      noe1  = n1;
      noe2  = n2;
      le    = leV;
      aIn   = aV;
      @(negedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkReleased(input string name, input int i);
      nChecks++;
      if (!busMatches(yOf(i), widthOf(i), 1'b0, '0)) begin
         nFails++;
         $display("[TB] FAIL %s: got %h expected Z", name, yOf(i));
      end
   endtask

   initial begin
      reset = 1'b1;
      noe1  = 1'b0;
      noe2  = 1'b0;
      le    = 1'b0;
      aIn   = 32'hA5;

      // Reset with both enables low: bus stays released.
      applyStimulus(1, 0, 0, 0, 32'hA5);
      applyStimulus(1, 0, 0, 0, 32'hA5);
      checkOutput("reset drive", 32'(driveV[0]), 32'h0);
      checkOutput("reset busy", 32'(busyV[0]), 32'h0);
      checkReleased("reset y", 0);

      // Release reset, enables low, a=3C: two busy edges then drive.
      applyStimulus(0, 0, 0, 1, 32'h3C);
      checkOutput("first edge after reset drive", 32'(driveV[0]), 32'h0);
      checkReleased("first edge after reset y", 0);
      applyStimulus(0, 0, 0, 1, 32'h3C);
      checkOutput("turn edge1 busy", 32'(busyV[0]), 32'h1);
      checkReleased("turn edge1 y", 0);
      checkOutput("T0 drive after 1 edge", yOf(2), 32'h003C);
      checkOutput("T0 busy never", 32'(busyV[2]), 32'h0);
      applyStimulus(0, 0, 0, 1, 32'h3C);
      checkOutput("turn edge2 busy", 32'(busyV[0]), 32'h1);
      applyStimulus(0, 0, 0, 1, 32'h3C);
      checkOutput("edge3 drive", 32'(driveV[0]), 32'h1);
      checkOutput("edge3 y", yOf(0), 32'h3C);

      // Raise noe2 while driving: released in the same cycle.
      applyStimulus(0, 0, 1, 0, 32'h3C);
      checkOutput("noe2 release drive", 32'(driveV[0]), 32'h0);
      checkReleased("noe2 release y", 0);
      applyStimulus(0, 0, 0, 0, 32'h3C);
      applyStimulus(0, 0, 0, 0, 32'h3C);
      checkOutput("reenable edge1 drive", 32'(driveV[0]), 32'h0);
      applyStimulus(0, 0, 0, 0, 32'h3C);
      checkOutput("reenable edge2 drive", 32'(driveV[0]), 32'h0);
      applyStimulus(0, 0, 0, 0, 32'h3C);
      checkOutput("reenable edge3 y", yOf(0), 32'h3C);

      // Latch mode: capture 5A on le, then a=FF without le.
      applyStimulus(0, 0, 0, 1, 32'h5A);
      applyStimulus(0, 0, 0, 0, 32'hFF);
      applyStimulus(0, 0, 0, 0, 32'hFF);
      checkOutput("latch hold y", yOf(1), 32'h5A);
      checkOutput("no latch y", yOf(0), 32'hFF);

      // Enable dropout mid-turnaround restarts the full delay.
      applyStimulus(1, 0, 0, 0, 32'h11);
      applyStimulus(0, 0, 0, 0, 32'h11);
      applyStimulus(0, 0, 0, 0, 32'h11);
      checkOutput("dropout pre busy", 32'(busyV[0]), 32'h1);
      applyStimulus(0, 1, 0, 0, 32'h11);
      checkOutput("dropout cycle busy", 32'(busyV[0]), 32'h1);
      applyStimulus(0, 0, 0, 0, 32'h11);
      checkOutput("dropout back to HIZ busy", 32'(busyV[0]), 32'h0);
      checkOutput("dropout no early drive", 32'(driveV[0]), 32'h0);
      applyStimulus(0, 0, 0, 0, 32'h11);
      checkOutput("restart edge1 busy", 32'(busyV[0]), 32'h1);
      applyStimulus(0, 0, 0, 0, 32'h11);
      checkOutput("restart edge2 busy", 32'(busyV[0]), 32'h1);
      applyStimulus(0, 0, 0, 0, 32'h11);
      checkOutput("restart edge3 y", yOf(0), 32'h11);

      // Sweep every enable combination across all byte values.
      for (int c = 0; c < 4; c++) begin
         for (int v = 0; v < 256; v++) begin
            applyStimulus(0, c[1], c[0], 1'b1, 32'(v) | (32'(v) << 8));
         end
      end

      // Randomized traffic biased toward long enabled runs.
      for (int n = 0; n < 3000; n++) begin
         int  r;
         int  sel;
         bit  n1;
         bit  n2;
         r   = $urandom_range(0, 99);
         sel = $urandom_range(0, 9);
         n1  = 1'b0;
         n2  = 1'b0;
         if (sel == 8) begin
            n1 = 1'b1;
         end else if (sel == 9) begin
            n1 = 1'($urandom);
            n2 = 1'($urandom);
         end
         applyStimulus(r < 2, n1, n2, 1'($urandom), $urandom);
      end

      applyStimulus(0, 1, 1, 0, 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
